// File: rtl/counter_mod8_pkg.sv
// Shared constants and types for the modulo-8 terminal-count counter.
package counter_mod8_pkg;

  localparam int CNT_W   = 3;
  localparam int MODULUS = 8;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t TC_VALUE = 3'd7;

  // Successor of a count value; the 3-bit width gives the mod-8 wrap.
  function automatic count_t next_count(input count_t c);
    return c + 3'd1;
  endfunction

endpackage

// File: rtl/counter_mod_8_t_ff.sv
// Toggle flip-flop with synchronous active-high clear.
// Clear has priority over the toggle enable.
module t_ff (
  input  logic clock,
  input  logic clear,
  input  logic t,
  output logic q
);

  logic q_reg;

  // Clear to zero, otherwise invert the stored bit when t is high.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_reg <= 1'b0;
    end else if (t) begin
      q_reg <= ~q_reg;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/counter_mod_8.sv
// Free-running modulo-8 counter built from a synchronous T flip-flop chain.
// F is high for exactly one clock in eight (count == 7) and serves as a
// divide-by-8 tick. clearn is an active-high synchronous clear.
// Optional macro COUNTER_MOD8_ASSERT_EN compiles in simulation-only checks.
module counter_mod_8
  import counter_mod8_pkg::*;
(
  input  logic clock,
  input  logic clearn,
  output logic F
);

  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] t_en;
  count_t           count;

  // Bit gi toggles when every lower bit is 1 (all flops share one clock).
  assign t_en[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < CNT_W; gi++) begin : g_ten
      assign t_en[gi] = t_en[gi-1] & q[gi-1];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < CNT_W; gi++) begin : g_bit
      t_ff u_tff (
        .clock (clock),
        .clear (clearn),
        .t     (t_en[gi]),
        .q     (q[gi])
      );
    end
  endgenerate

  assign count = q;

  // Terminal-count decode of registered state only.
  assign F = (count == TC_VALUE);

`ifdef COUNTER_MOD8_ASSERT_EN
  logic   chk_valid;
  logic   clr_s;
  count_t cnt_s;
  logic   f_s;

  // At each edge the flops still hold the result of the previous edge, so
  // compare that against what was sampled one edge earlier.
  always @(posedge clock) begin
    if (chk_valid) begin
      if (clr_s) begin
        assert (count == '0) else $error("count not cleared");
      end else if (!$isunknown(cnt_s)) begin
        assert (count == next_count(cnt_s)) else $error("count did not advance by one");
      end
      if (!$isunknown(f_s) && !$isunknown(F)) begin
        assert (!(f_s && F)) else $error("F high two consecutive cycles");
      end
    end
    if (!$isunknown(count)) begin
      assert (F == (count == TC_VALUE)) else $error("F decode inconsistent");
    end
    chk_valid <= 1'b1;
    clr_s     <= clearn;
    cnt_s     <= count;
    f_s       <= F;
  end
`endif

endmodule

// File: tb/tb_counter_mod_8.sv
// Directed bench for counter_mod_8: vector table plus corner-case sequences.
module tb_counter_mod_8;

  logic clock;
  logic clearn;
  logic F;

  int checks;
  int passed;

  typedef struct {
    logic       clr;
    logic [2:0] exp_count;
    logic       exp_f;
  } vec_t;

  vec_t vecs[$];

  counter_mod_8 dut (
    .clock  (clock),
    .clearn (clearn),
    .F      (F)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [2:0] exp_c, input logic exp_f);
    checks++;
    if (dut.count === exp_c) passed++;
    else $display("FAIL %s: count got %0d expected %0d", name, dut.count, exp_c);
    checks++;
    if (F === exp_f) passed++;
    else $display("FAIL %s: F got %b expected %b", name, F, exp_f);
  endtask

  // Drive clearn between edges, take one rising edge, sample 1 ns later.
  task automatic step(input string name, input logic clr, input logic [2:0] exp_c, input logic exp_f);
    clearn = clr;
    @(posedge clock);
    #1;
    check(name, exp_c, exp_f);
    $display("%s: clr=%b count=%0d F=%b (exp %0d/%b)", name, clr, dut.count, F, exp_c, exp_f);
  endtask

  function automatic vec_t mk(input logic clr, input logic [2:0] c, input logic f);
    vec_t v;
    v.clr = clr;
    v.exp_count = c;
    v.exp_f = f;
    return v;
  endfunction

  initial begin
    checks = 0;
    passed = 0;
    clearn = 1'b1;

    // Power-up clear (2 edges), free count of 16 edges, mid-count clear at 3.
    vecs.push_back(mk(1'b1, 3'd0, 1'b0));
    vecs.push_back(mk(1'b1, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 3'd4, 1'b0));
    vecs.push_back(mk(1'b0, 3'd5, 1'b0));
    vecs.push_back(mk(1'b0, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 3'd7, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 3'd3, 1'b0));
    vecs.push_back(mk(1'b0, 3'd4, 1'b0));
    vecs.push_back(mk(1'b0, 3'd5, 1'b0));
    vecs.push_back(mk(1'b0, 3'd6, 1'b0));
    vecs.push_back(mk(1'b0, 3'd7, 1'b1));
    vecs.push_back(mk(1'b0, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'd2, 1'b0));
    vecs.push_back(mk(1'b0, 3'd3, 1'b0));
    vecs.push_back(mk(1'b1, 3'd0, 1'b0));
    vecs.push_back(mk(1'b0, 3'd1, 1'b0));
    vecs.push_back(mk(1'b0, 3'd2, 1'b0));

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].clr, vecs[i].exp_count, vecs[i].exp_f);
    end

    // Clear at terminal count: count is 2 here, advance to 7.
    for (int c = 3; c <= 7; c++) begin
      step("to_tc", 1'b0, 3'(c), (c == 7));
    end
    step("clr_at_tc", 1'b1, 3'd0, 1'b0);
    for (int c = 1; c <= 7; c++) begin
      step("after_tc_clr", 1'b0, 3'(c), (c == 7));
    end

    // Sub-cycle clear pulse between edges must be ignored (count now 7).
    step("pre_pulse", 1'b0, 3'd0, 1'b0);
    #2 clearn = 1'b1;
    #4 clearn = 1'b0;
    step("post_pulse", 1'b0, 3'd1, 1'b0);
    for (int c = 2; c <= 7; c++) begin
      step("pulse_spacing", 1'b0, 3'(c), (c == 7));
    end
    step("pulse_wrap", 1'b0, 3'd0, 1'b0);

    // Long clear of 10 edges, then first counting edge gives 1.
    step("pre_long", 1'b0, 3'd1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("long_clr", 1'b1, 3'd0, 1'b0);
    end
    step("long_release", 1'b0, 3'd1, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/counter_mod_8.md
# counter_mod_8

Free-running synchronous modulo-8 counter with a single terminal-count output. It counts clock edges 0→7 and wraps, asserting `F` for exactly one clock period out of every eight, and is used as a divide-by-8 tick/enable source for downstream sequential logic. A synchronous clear forces the count to zero.

## Interface
- Parameters: none; modulus fixed at 8, state width fixed at 3 bits.
- `clock`  input  1  single system clock; all state updates on its rising edge.
- `clearn`  input  1  synchronous, active-high clear; sampled on rising `clock`.
- `F`  output  1  terminal-count flag; high exactly while internal count == 7.

## Operation
- Internal 3-bit state `count`, unsigned, values 0..7.
- Rising `clock` with `clearn` = 1: `count` ← 0 (clear wins over counting).
- Rising `clock` with `clearn` = 0: `count` ← (`count` + 1) mod 8; 7 wraps to 0 with no other effect.
- `F` = (`count` == 3'd7); pure decode of registered state, no combinational path from `clearn` or `clock` to `F`.
- No asynchronous behaviour; `clearn` changing between edges has no effect until the next rising edge.
- No power-on initialisation: `count` and `F` are undefined (X in simulation) until the first rising edge with `clearn` = 1.
- Holding `clearn` = 1 for any number of cycles keeps `count` = 0, `F` = 0.
- Clear asserted while `count` == 7: next edge `count` = 0, `F` falls; no extra `F` cycle.

## Timing
- Reset values after a clearing edge: `count` = 0, `F` = 0.
- Edge at which `clearn` is released counts as a counting edge: the first edge sampling `clearn` = 0 after a clear moves `count` 0→1.
- `F` rises after the 7th counting edge after clear release and falls on the 8th; period of `F` = 8 clocks, duty 1/8.
- Latency `clearn` → `F` = 0: one clock edge (or already 0).
- `F` changes only immediately after rising `clock` (clock-to-Q of state flops plus decode).
- Clear pulse shorter than a clock period and not spanning a rising edge is ignored.

## Configuration
- `COUNTER_MOD8_ASSERT_EN` defined: simulation-only assertions compiled in: (a) after a rising edge with `clearn` = 1, `count` == 0; (b) with `clearn` = 0 and `count` known, `count` advances by exactly 1 mod 8; (c) `F` == (`count` == 7) at all times; (d) `F` never high two consecutive cycles.
- Macro undefined: no assertion code; RTL and port list identical.

## Structure
- Package `counter_mod8_pkg`: `CNT_W` = 3, `MODULUS` = 8, `TC_VALUE` = 3'd7, typedef `count_t` (logic [CNT_W-1:0]).
- Natural sub-module `t_ff`: toggle flip-flop with synchronous active-high clear (ports `clock`, `clear`, `t`, `q`); top instantiates three, with T inputs `t0` = 1, `t1` = q0, `t2` = q0 & q1 (synchronous toggle chain, not ripple).
- Top contains only instances, T-enable logic and the `F` decode.

## Test plan
- Power-up: clock runs, `clearn` = 1 for 2 edges -> `count` = 0, `F` = 0 after first such edge.
- Free count: release `clearn`, run 16 edges -> `count` sequence 1..7,0..7,0; `F` high exactly after edges 7 and 15, one cycle each.
- Clear at terminal count: assert `clearn` while `count` = 7 -> next edge `count` = 0, `F` = 0; after release, `F` next high 7 edges later.
- Mid-count clear: `clearn` = 1 for one edge at `count` = 3 -> `count` = 0; sequence restarts 1,2,….
- Sub-cycle pulse: `clearn` high for 0.5 clock period between rising edges -> count unaffected, `F` spacing stays 8.
- Long clear: `clearn` = 1 for 10 edges -> `count` = 0, `F` = 0 throughout; first edge after release gives `count` = 1.
